// File: rtl/i2s_pkg.sv
// Shared constants and the slot builder for the I2S-family serialiser.
// A slot is built right-aligned in a MAX_SLOT-wide vector; callers keep the low SLOT_WIDTH bits.
package i2s_pkg;

   localparam logic [1:0] FMT_I2S = 2'd0;
   localparam logic [1:0] FMT_LJ  = 2'd1;
   localparam logic [1:0] FMT_RJ  = 2'd2;

   localparam int unsigned         MAX_SLOT = 64;
   localparam logic [MAX_SLOT-1:0] SLOT_ONE = MAX_SLOT'(1);

   typedef logic [1:0] fmt_t;

   // Sample arrives zero-extended; RJ sign-extends it, every other format left-justifies it.
   function automatic logic [MAX_SLOT-1:0] build_slot(
      input logic [MAX_SLOT-1:0] sample,
      input int unsigned         sample_w,
      input int unsigned         slot_w,
      input fmt_t                fmt
   );
      logic [MAX_SLOT-1:0] mask;
      logic [MAX_SLOT-1:0] high;
      logic [MAX_SLOT-1:0] slot;
      mask = (SLOT_ONE << slot_w) - SLOT_ONE;
      high = ~((SLOT_ONE << sample_w) - SLOT_ONE);
      if (fmt == FMT_RJ) begin
         if ((sample & (SLOT_ONE << (sample_w - 1))) != '0) begin
            slot = (sample | high) & mask;
         end else begin
            slot = sample & mask;
         end
      end else begin
         slot = (sample << (slot_w - sample_w)) & mask;
      end
      return slot;
   endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: toggles bclk every BCLK_HALF clk cycles while enabled and
// flags the cycle before each toggle with a rise or fall strobe.
module i2s_bclk_gen #(
   parameter int unsigned BCLK_HALF = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic bclk,
   output logic rise,
   output logic fall
);
   localparam int unsigned CW = $clog2(BCLK_HALF);

   logic [CW-1:0] cnt_q;
   logic          wrap;

   assign wrap = enable && (cnt_q == CW'(BCLK_HALF - 1));
   assign rise = wrap && !bclk;
   assign fall = wrap && bclk;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
         bclk  <= 1'b0;
      end else if (!enable) begin
         cnt_q <= '0;
         bclk  <= 1'b0;
      end else if (wrap) begin
         cnt_q <= '0;
         bclk  <= ~bclk;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/i2s_tx_fmt.sv
// Stereo I2S / left-justified / right-justified serialiser with a one-deep
// holding register, internal BCLK and a mute-or-repeat underrun policy.
module i2s_tx_fmt
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH  = 24,
   parameter int unsigned SLOT_WIDTH    = 32,
   parameter int unsigned BCLK_HALF     = 4,
   parameter bit          UNDERRUN_MUTE = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [1:0]              fmt,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [SAMPLE_WIDTH-1:0] in_left,
   input  logic [SAMPLE_WIDTH-1:0] in_right,
   output logic                    bclk,
   output logic                    lrclk,
   output logic                    sdata,
   output logic                    underrun
);
   localparam int unsigned   FW     = 2 * SLOT_WIDTH;
   localparam int unsigned   BW     = $clog2(FW);
   localparam logic [BW-1:0] B_LAST = BW'(FW - 1);

   logic                    bclk_rise;
   logic                    bclk_fall;
   logic                    hold_full_q;
   logic [SAMPLE_WIDTH-1:0] hold_left_q;
   logic [SAMPLE_WIDTH-1:0] hold_right_q;
   logic [SAMPLE_WIDTH-1:0] last_left_q;
   logic [SAMPLE_WIDTH-1:0] last_right_q;
   fmt_t                    fmt_q;
   logic [FW-1:0]           frame_q;
   logic [BW-1:0]           b_q;
   logic                    active_q;
   logic                    start_q;
   logic                    delay_q;

   logic                    load;
   logic [SAMPLE_WIDTH-1:0] src_left;
   logic [SAMPLE_WIDTH-1:0] src_right;
   logic [SLOT_WIDTH-1:0]   slot_left;
   logic [SLOT_WIDTH-1:0]   slot_right;
   logic [FW-1:0]           new_frame;
   logic [FW-1:0]           frame_src;
   logic [BW-1:0]           b_next;
   logic [BW-1:0]           idx;
   fmt_t                    fmt_sel;
   logic                    is_i2s;
   logic                    sdata_next;

   i2s_bclk_gen #(
      .BCLK_HALF(BCLK_HALF)
   ) u_bclk_gen (
      .clk   (clk),
      .reset (reset),
      .enable(enable),
      .bclk  (bclk),
      .rise  (bclk_rise),
      .fall  (bclk_fall)
   );

   assign in_ready = !hold_full_q;
   // start_q is decided at the rise so the following fall knows it begins a frame.
   assign load     = bclk_fall && start_q;

   always_comb begin
      src_left   = hold_full_q ? hold_left_q  : (UNDERRUN_MUTE ? '0 : last_left_q);
      src_right  = hold_full_q ? hold_right_q : (UNDERRUN_MUTE ? '0 : last_right_q);
      slot_left  = SLOT_WIDTH'(build_slot(MAX_SLOT'(src_left), SAMPLE_WIDTH, SLOT_WIDTH, fmt));
      slot_right = SLOT_WIDTH'(build_slot(MAX_SLOT'(src_right), SAMPLE_WIDTH, SLOT_WIDTH, fmt));
      new_frame  = {slot_left, slot_right};
      b_next     = load ? '0 : b_q + 1'b1;
      frame_src  = load ? new_frame : frame_q;
      fmt_sel    = load ? fmt : fmt_q;
      is_i2s     = (fmt_sel != FMT_LJ) && (fmt_sel != FMT_RJ);
      // I2S runs one bit behind; its b = 0 bit comes from the previous frame via delay_q.
      idx        = is_i2s ? (BW'(FW) - b_next) : (B_LAST - b_next);
      sdata_next = (is_i2s && (b_next == '0)) ? delay_q : frame_src[idx];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_full_q  <= 1'b0;
         hold_left_q  <= '0;
         hold_right_q <= '0;
         last_left_q  <= '0;
         last_right_q <= '0;
      end else if (load && hold_full_q) begin
         hold_full_q  <= 1'b0;
         last_left_q  <= hold_left_q;
         last_right_q <= hold_right_q;
      end else if (in_valid && !hold_full_q) begin
         hold_full_q  <= 1'b1;
         hold_left_q  <= in_left;
         hold_right_q <= in_right;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fmt_q    <= FMT_I2S;
         frame_q  <= '0;
         b_q      <= '0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
         delay_q  <= 1'b0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else if (!enable) begin
         b_q      <= '0;
         active_q <= 1'b0;
         start_q  <= 1'b0;
         delay_q  <= 1'b0;
         lrclk    <= 1'b0;
         sdata    <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= load && !hold_full_q;
         if (bclk_rise) begin
            start_q <= !active_q || (b_q == B_LAST);
         end
         if (bclk_fall) begin
            b_q   <= b_next;
            lrclk <= (b_next >= BW'(SLOT_WIDTH));
            sdata <= sdata_next;
            if (b_next == B_LAST) begin
               delay_q <= frame_q[0];
            end
         end
         if (load) begin
            active_q <= 1'b1;
            fmt_q    <= fmt;
            frame_q  <= new_frame;
         end
      end
   end

endmodule

// File: tb/tb_i2s_tx_fmt.sv
// Directed bench for i2s_tx_fmt: three instances (default mute, 16-bit samples,
// repeat-on-underrun) exercised one at a time against hand-computed frames.
module tb_i2s_tx_fmt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic        a_enable, a_valid, a_ready, a_bclk, a_lrclk, a_sdata, a_underrun;
   logic [1:0]  a_fmt;
   logic [23:0] a_left, a_right;

   logic        b_enable, b_valid, b_ready, b_bclk, b_lrclk, b_sdata, b_underrun;
   logic [1:0]  b_fmt;
   logic [15:0] b_left, b_right;

   logic        c_enable, c_valid, c_ready, c_bclk, c_lrclk, c_sdata, c_underrun;
   logic [1:0]  c_fmt;
   logic [23:0] c_left, c_right;

   int errors = 0;
   int checks = 0;
   int pos    = 0;

   i2s_tx_fmt u_dut_a (
      .clk(clk), .reset(reset), .enable(a_enable), .fmt(a_fmt), .in_valid(a_valid),
      .in_ready(a_ready), .in_left(a_left), .in_right(a_right), .bclk(a_bclk),
      .lrclk(a_lrclk), .sdata(a_sdata), .underrun(a_underrun)
   );

   i2s_tx_fmt #(
      .SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .BCLK_HALF(4), .UNDERRUN_MUTE(1'b1)
   ) u_dut_b (
      .clk(clk), .reset(reset), .enable(b_enable), .fmt(b_fmt), .in_valid(b_valid),
      .in_ready(b_ready), .in_left(b_left), .in_right(b_right), .bclk(b_bclk),
      .lrclk(b_lrclk), .sdata(b_sdata), .underrun(b_underrun)
   );

   i2s_tx_fmt #(
      .SAMPLE_WIDTH(24), .SLOT_WIDTH(32), .BCLK_HALF(4), .UNDERRUN_MUTE(1'b0)
   ) u_dut_c (
      .clk(clk), .reset(reset), .enable(c_enable), .fmt(c_fmt), .in_valid(c_valid),
      .in_ready(c_ready), .in_left(c_left), .in_right(c_right), .bclk(c_bclk),
      .lrclk(c_lrclk), .sdata(c_sdata), .underrun(c_underrun)
   );

   // pos counts rising edges since the enable under test was raised; lands 1 ns after edge k.
   task automatic step_to(input int k);
      if (k > pos) begin
         repeat (k - pos) @(posedge clk);
         pos = k;
         #1;
      end
   endtask

   // Bit n of a frame is sampled mid-BCLK-high, edge 12 + 8n after enable.
   task automatic capture(input int dut, input int n0, output logic [63:0] sd,
                          output logic [63:0] lr);
      sd = '0;
      lr = '0;
      for (int n = 0; n < 64; n++) begin
         step_to(12 + 8 * (n0 + n));
         case (dut)
            0:       begin sd = {sd[62:0], a_sdata}; lr = {lr[62:0], a_lrclk}; end
            1:       begin sd = {sd[62:0], b_sdata}; lr = {lr[62:0], b_lrclk}; end
            default: begin sd = {sd[62:0], c_sdata}; lr = {lr[62:0], c_lrclk}; end
         endcase
      end
   endtask

   task automatic do_reset;
      reset    = 1'b1;
      a_enable = 1'b0; a_valid = 1'b0; a_fmt = 2'd0; a_left = '0; a_right = '0;
      b_enable = 1'b0; b_valid = 1'b0; b_fmt = 2'd0; b_left = '0; b_right = '0;
      c_enable = 1'b0; c_valid = 1'b0; c_fmt = 2'd0; c_left = '0; c_right = '0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      pos   = 0;
   endtask

   task automatic test_reset;
      do_reset();
      reset = 1'b1;
      #1;
      checks++;
      if ({a_bclk, a_lrclk, a_sdata, a_underrun, a_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL reset_a_outputs: got %b expected 00001",
                  {a_bclk, a_lrclk, a_sdata, a_underrun, a_ready});
      end
      checks++;
      if ({b_ready, c_ready} !== 2'b11) begin
         errors++;
         $display("FAIL reset_bc_ready: got %b expected 11", {b_ready, c_ready});
      end
      reset = 1'b0;
   endtask

   task automatic test_i2s_frame;
      logic [63:0] sd, lr;
      do_reset();
      a_fmt = 2'd0; a_left = 24'h800001; a_right = 24'h7FFFFE; a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid  = 1'b0;
      a_enable = 1'b1;
      pos      = 0;
      step_to(7);
      checks++;
      if (a_ready !== 1'b0) begin
         errors++;
         $display("FAIL i2s_ready_before_load: got %b expected 0", a_ready);
      end
      step_to(8);
      checks++;
      if ({a_ready, a_underrun} !== 2'b10) begin
         errors++;
         $display("FAIL i2s_ready_after_load: got %b expected 10", {a_ready, a_underrun});
      end
      capture(0, 0, sd, lr);
      checks++;
      if (sd !== 64'h4000_0080_3FFF_FF00) begin
         errors++;
         $display("FAIL i2s_frame_bits: got %h expected 40000080_3fffff00", sd);
      end
      checks++;
      if (lr !== 64'h0000_0000_FFFF_FFFF) begin
         errors++;
         $display("FAIL i2s_lrclk: got %h expected 00000000_ffffffff", lr);
      end
      step_to(520);
      checks++;
      if ({a_sdata, a_underrun, a_lrclk} !== 3'b010) begin
         errors++;
         $display("FAIL i2s_next_frame_b0: got %b expected 010", {a_sdata, a_underrun, a_lrclk});
      end
      step_to(521);
      checks++;
      if (a_underrun !== 1'b0) begin
         errors++;
         $display("FAIL i2s_underrun_width: got %b expected 0", a_underrun);
      end
      a_enable = 1'b0;
   endtask

   task automatic test_lj_rj;
      logic [63:0] sd, lr;
      do_reset();
      b_fmt = 2'd1; b_left = 16'hC000; b_right = 16'h1234; b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid  = 1'b0;
      b_enable = 1'b1;
      pos      = 0;
      step_to(9);
      b_fmt   = 2'd2;
      b_valid = 1'b1;
      step_to(10);
      b_valid = 1'b0;
      checks++;
      if (b_ready !== 1'b0) begin
         errors++;
         $display("FAIL ljrj_second_accept: got %b expected 0", b_ready);
      end
      capture(1, 0, sd, lr);
      checks++;
      if (sd !== 64'hC000_0000_1234_0000) begin
         errors++;
         $display("FAIL lj_frame: got %h expected c0000000_12340000", sd);
      end
      step_to(520);
      checks++;
      if (b_underrun !== 1'b0) begin
         errors++;
         $display("FAIL ljrj_no_underrun: got %b expected 0", b_underrun);
      end
      capture(1, 64, sd, lr);
      checks++;
      if (sd !== 64'hFFFF_C000_0000_1234) begin
         errors++;
         $display("FAIL rj_frame: got %h expected ffffc000_00001234", sd);
      end
      b_enable = 1'b0;
   endtask

   task automatic test_underrun_mute;
      int n_under = 0;
      int n_data  = 0;
      int n_bclk  = 0;
      do_reset();
      a_enable = 1'b1;
      pos      = 0;
      for (int k = 1; k <= 1040; k++) begin
         step_to(k);
         if (a_underrun === 1'b1) n_under++;
         if (a_sdata !== 1'b0) n_data++;
         if (a_bclk === 1'b1) n_bclk++;
      end
      checks++;
      if (n_under !== 3) begin
         errors++;
         $display("FAIL mute_underrun_pulses: got %0d expected 3", n_under);
      end
      checks++;
      if (n_data !== 0) begin
         errors++;
         $display("FAIL mute_sdata_ones: got %0d expected 0", n_data);
      end
      checks++;
      if (n_bclk !== 520) begin
         errors++;
         $display("FAIL mute_bclk_high_cycles: got %0d expected 520", n_bclk);
      end
      a_enable = 1'b0;
   endtask

   task automatic test_underrun_repeat;
      logic [63:0] sd, lr;
      do_reset();
      c_fmt = 2'd0; c_left = 24'h123456; c_right = 24'h654321; c_valid = 1'b1;
      @(posedge clk);
      #1;
      c_valid  = 1'b0;
      c_enable = 1'b1;
      pos      = 0;
      step_to(8);
      checks++;
      if (c_underrun !== 1'b0) begin
         errors++;
         $display("FAIL repeat_first_load: got %b expected 0", c_underrun);
      end
      capture(2, 0, sd, lr);
      checks++;
      if (sd !== 64'h091A_2B00_32A1_9080) begin
         errors++;
         $display("FAIL repeat_frame1: got %h expected 091a2b00_32a19080", sd);
      end
      step_to(520);
      checks++;
      if (c_underrun !== 1'b1) begin
         errors++;
         $display("FAIL repeat_underrun2: got %b expected 1", c_underrun);
      end
      capture(2, 64, sd, lr);
      checks++;
      if (sd !== 64'h091A_2B00_32A1_9080) begin
         errors++;
         $display("FAIL repeat_frame2: got %h expected 091a2b00_32a19080", sd);
      end
      step_to(1032);
      checks++;
      if (c_underrun !== 1'b1) begin
         errors++;
         $display("FAIL repeat_underrun3: got %b expected 1", c_underrun);
      end
      c_enable = 1'b0;
   endtask

   task automatic test_simultaneous;
      logic [63:0] sd, lr;
      do_reset();
      a_fmt = 2'd1; a_left = 24'hA5A5A5; a_right = 24'h5A5A5A;
      a_enable = 1'b1;
      pos      = 0;
      step_to(7);
      checks++;
      if (a_ready !== 1'b1) begin
         errors++;
         $display("FAIL simul_ready_pre: got %b expected 1", a_ready);
      end
      a_valid = 1'b1;
      step_to(8);
      a_valid = 1'b0;
      checks++;
      if ({a_underrun, a_ready} !== 2'b10) begin
         errors++;
         $display("FAIL simul_load_cycle: got %b expected 10", {a_underrun, a_ready});
      end
      step_to(9);
      checks++;
      if (a_underrun !== 1'b0) begin
         errors++;
         $display("FAIL simul_underrun_width: got %b expected 0", a_underrun);
      end
      capture(0, 0, sd, lr);
      checks++;
      if (sd !== 64'h0) begin
         errors++;
         $display("FAIL simul_frame1_muted: got %h expected 0", sd);
      end
      step_to(521);
      checks++;
      if ({a_underrun, a_ready} !== 2'b01) begin
         errors++;
         $display("FAIL simul_second_load: got %b expected 01", {a_underrun, a_ready});
      end
      capture(0, 64, sd, lr);
      checks++;
      if (sd !== 64'hA5A5_A500_5A5A_5A00) begin
         errors++;
         $display("FAIL simul_frame2: got %h expected a5a5a500_5a5a5a00", sd);
      end
      a_enable = 1'b0;
   endtask

   task automatic test_enable_reset;
      do_reset();
      a_fmt = 2'd0; a_left = 24'h800001; a_right = 24'h7FFFFE; a_valid = 1'b1;
      @(posedge clk);
      #1;
      a_valid  = 1'b0;
      a_enable = 1'b1;
      pos      = 0;
      step_to(12 + 8 * 40);
      checks++;
      if ({a_bclk, a_lrclk, a_sdata} !== 3'b111) begin
         errors++;
         $display("FAIL en_mid_right_slot: got %b expected 111", {a_bclk, a_lrclk, a_sdata});
      end
      a_enable = 1'b0;
      step_to(12 + 8 * 40 + 1);
      checks++;
      if ({a_bclk, a_lrclk, a_sdata, a_underrun} !== 4'b0000) begin
         errors++;
         $display("FAIL en_disable_outputs: got %b expected 0000",
                  {a_bclk, a_lrclk, a_sdata, a_underrun});
      end
      step_to(340);
      a_enable = 1'b1;
      pos      = 0;
      step_to(3);
      checks++;
      if (a_bclk !== 1'b0) begin
         errors++;
         $display("FAIL en_bclk_early: got %b expected 0", a_bclk);
      end
      step_to(4);
      checks++;
      if (a_bclk !== 1'b1) begin
         errors++;
         $display("FAIL en_first_rise: got %b expected 1", a_bclk);
      end
      step_to(8);
      checks++;
      if ({a_bclk, a_underrun, a_sdata, a_lrclk, a_ready} !== 5'b01001) begin
         errors++;
         $display("FAIL en_fresh_load: got %b expected 01001",
                  {a_bclk, a_underrun, a_sdata, a_lrclk, a_ready});
      end
      a_valid = 1'b1;
      step_to(9);
      a_valid = 1'b0;
      step_to(12);
      checks++;
      if ({a_bclk, a_ready} !== 2'b10) begin
         errors++;
         $display("FAIL en_pre_reset_state: got %b expected 10", {a_bclk, a_ready});
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({a_bclk, a_lrclk, a_sdata, a_underrun, a_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL async_reset: got %b expected 00001",
                  {a_bclk, a_lrclk, a_sdata, a_underrun, a_ready});
      end
      a_enable = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_i2s_frame();
      test_lj_rj();
      test_underrun_mute();
      test_underrun_repeat();
      test_simultaneous();
      test_enable_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
